passcode_serializer: RTL

//   Upstream feed for sequenceDetector. Accepts whole passcodes as parallel words over a valid/ready handshake.

---
 rtl/passcode_serializer_if.sv | 24 ++
 rtl/passcode_serializer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/passcode_serializer_if.sv
// Parallel passcode handshake between a code source and the serializer.
interface passcode_serializer_if #(
  parameter int unsigned CODE_WIDTH = 4
);

  logic [CODE_WIDTH-1:0] codeIn;
  logic                  codeValid;
  logic                  codeReady;

  // Source side drives the word and its valid.
  modport master (
    output codeIn,
    output codeValid,
    input  codeReady
  );

  // Serializer side consumes the word and returns ready.
  modport slave (
    input  codeIn,
    input  codeValid,
    output codeReady
  );

endinterface

// File: rtl/passcode_serializer.sv
// Serializes whole passcodes onto a single bit line for sequenceDetector.
// A one-entry hold register in front of the shifter lets codes stream
// back-to-back; optional idle gap cycles follow each code.
module passcode_serializer #(
  parameter int unsigned CODE_WIDTH = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  asyncReset,
  passcode_serializer_if.slave  code_if,
  output logic                  dataOut,
  output logic                  bitValid,
  output logic                  frameStart,
  output logic                  frameDone,
  output logic                  busy
);

  localparam int unsigned CNT_W = (CODE_WIDTH > 2) ? $clog2(CODE_WIDTH) : 1;
  localparam int unsigned GAP_W = 8;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CODE_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]            state_q,      state_d;
  logic [CODE_WIDTH-1:0] hold_q,       hold_d;
  logic                  hold_full_q,  hold_full_d;
  logic [CODE_WIDTH-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q,    gap_cnt_d;

  logic                  code_ready_q,  code_ready_d;
  logic                  data_out_q,    data_out_d;
  logic                  bit_valid_q,   bit_valid_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_done_q,  frame_done_d;
  logic                  busy_q,        busy_d;

  logic                  accept_c;
  logic                  load_c;

  // Bit currently presented by a shifter image.
  function automatic logic cur_bit(input logic [CODE_WIDTH-1:0] s);
    return MSB_FIRST ? s[CODE_WIDTH-1] : s[0];
  endfunction

  // Shifter image after presenting its current bit.
  function automatic logic [CODE_WIDTH-1:0] advance(input logic [CODE_WIDTH-1:0] s);
    return MSB_FIRST ? {s[CODE_WIDTH-2:0], 1'b0} : {1'b0, s[CODE_WIDTH-1:1]};
  endfunction

  // Next-state, hold-register and registered-output computation.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    load_c      = 1'b0;
    accept_c    = code_if.codeValid && !hold_full_q;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) load_c = 1'b1;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else if (hold_full_q) begin
            load_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shift_d   = advance(shift_q);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (hold_full_q) load_c = 1'b1;
          else             state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Drain and accept are mutually exclusive: drain needs hold full, accept needs it empty.
    if (load_c) begin
      state_d     = ST_SHIFT;
      shift_d     = hold_q;
      bit_cnt_d   = '0;
      hold_full_d = 1'b0;
    end
    if (accept_c) begin
      hold_d      = code_if.codeIn;
      hold_full_d = 1'b1;
    end

    bit_valid_d   = (state_d == ST_SHIFT);
    data_out_d    = bit_valid_d ? cur_bit(shift_d) : IDLE_LEVEL;
    frame_start_d = bit_valid_d && (bit_cnt_d == '0);
    frame_done_d  = bit_valid_d && (bit_cnt_d == BIT_LAST);
    busy_d        = (state_d != ST_IDLE) || hold_full_d;
    code_ready_d  = !hold_full_d;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge asyncReset) begin
    if (!asyncReset) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      code_ready_q  <= 1'b1;
      data_out_q    <= IDLE_LEVEL;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      code_ready_q  <= code_ready_d;
      data_out_q    <= data_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign code_if.codeReady = code_ready_q;
  assign dataOut           = data_out_q;
  assign bitValid          = bit_valid_q;
  assign frameStart        = frame_start_q;
  assign frameDone         = frame_done_q;
  assign busy              = busy_q;

endmodule
